// File: rtl/data_memory.sv
// data_memory: sized (byte/half/word) data memory with configurable access latency and busy/done handshake.
// Optional macro MEMORY_BIG_ENDIAN_EN selects MIPS big-endian lane mapping; little-endian when undefined.
`ifndef WIDTH
`define WIDTH 32
`endif

module data_memory #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              memory_read,
   input  logic              memory_write,
   input  logic [1:0]        memory_size,
   input  logic              memory_unsigned,
   input  logic [`WIDTH-1:0] memory_address,
   input  logic [`WIDTH-1:0] memory_data_write,
   output logic [`WIDTH-1:0] memory_data_read,
   output logic              memory_busy,
   output logic              memory_done,
   output logic              memory_misaligned
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [CW-1:0]       cnt_r;
   logic [AW+1:0]       addr_r;
   logic [1:0]          size_r;
   logic                uns_r, write_r;
   logic [`WIDTH-1:0]   wdata_r;
   logic [`WIDTH-1:0]   data_read_r;
   logic                busy_r, done_r, mis_r;
   logic [`WIDTH-1:0]   mem_r [DEPTH];

   logic                req_s, entering_done_s;
   logic [AW+1:0]       cur_addr_s;
   logic [1:0]          cur_size_s, lane_s;
   logic                cur_uns_s, cur_write_s, mis_s;
   logic [AW-1:0]       idx_s;
   logic [4:0]          byte_sh_s, half_sh_s;
   logic [`WIDTH-1:0]   word_s, load_s, store_s;
   logic [7:0]          byte_s;
   logic [15:0]         half_s;
   logic [3:0]          be_s;
   logic                unused_addr_s;

   assign unused_addr_s = ^memory_address[`WIDTH-1:AW+2];

   // Request fields: live inputs while IDLE (covers LATENCY==1), latched copy afterwards
   always_comb begin
      req_s = memory_read | memory_write;
      if (state_r == ST_IDLE) begin
         cur_addr_s  = memory_address[AW+1:0];
         cur_size_s  = memory_size;
         cur_uns_s   = memory_unsigned;
         cur_write_s = memory_write;
      end else begin
         cur_addr_s  = addr_r;
         cur_size_s  = size_r;
         cur_uns_s   = uns_r;
         cur_write_s = write_r;
      end
      idx_s  = cur_addr_s[AW+1:2];
      lane_s = cur_addr_s[1:0];
   end

   // Alignment check and lane bit offsets
   always_comb begin
      case (cur_size_s)
         2'b00:   mis_s = 1'b0;
         2'b01:   mis_s = lane_s[0];
         default: mis_s = |lane_s;
      endcase
`ifdef MEMORY_BIG_ENDIAN_EN
      byte_sh_s = 5'd24 - {lane_s, 3'b000};
      half_sh_s = lane_s[1] ? 5'd0 : 5'd16;
`else
      byte_sh_s = {lane_s, 3'b000};
      half_sh_s = lane_s[1] ? 5'd16 : 5'd0;
`endif
   end

   // Load extraction with sign/zero extension, store lane placement and byte enables
   always_comb begin
      word_s = mem_r[idx_s];
      byte_s = word_s[byte_sh_s +: 8];
      half_s = word_s[half_sh_s +: 16];
      case (cur_size_s)
         2'b00: begin
            load_s  = cur_uns_s ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            be_s    = 4'b0001 << byte_sh_s[4:3];
            store_s = {24'd0, wdata_r[7:0]} << byte_sh_s;
         end
         2'b01: begin
            load_s  = cur_uns_s ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            be_s    = 4'b0011 << half_sh_s[4:3];
            store_s = {16'd0, wdata_r[15:0]} << half_sh_s;
         end
         default: begin
            load_s  = word_s;
            be_s    = 4'b1111;
            store_s = wdata_r;
         end
      endcase
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               state_s = (LATENCY == 1) ? ST_DONE : ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == CW'(1)) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
      entering_done_s = (state_s == ST_DONE) && (state_r != ST_DONE);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request latch, latency counter and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= '0;
         addr_r      <= '0;
         size_r      <= 2'b00;
         uns_r       <= 1'b0;
         write_r     <= 1'b0;
         wdata_r     <= '0;
         data_read_r <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         mis_r       <= 1'b0;
      end else begin
         if (state_r == ST_IDLE && req_s) begin
            addr_r  <= memory_address[AW+1:0];
            size_r  <= memory_size;
            uns_r   <= memory_unsigned;
            write_r <= memory_write;
            wdata_r <= memory_data_write;
            cnt_r   <= CW'(LATENCY - 1);
            busy_r  <= 1'b1;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CW'(1);
         end
         // Later assignment wins so busy drops in DONE even when LATENCY==1
         if (entering_done_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            mis_r  <= mis_s;
            if (!mis_s && !cur_write_s) begin
               data_read_r <= load_s;
            end
         end else if (state_r == ST_DONE) begin
            done_r <= 1'b0;
            mis_r  <= 1'b0;
         end
      end
   end

   // Byte-masked store, committed on the edge leaving DONE
   always_ff @(posedge clk) begin
      if (state_r == ST_DONE && write_r && !mis_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem_r[idx_s][8*b +: 8] <= store_s[8*b +: 8];
            end
         end
      end
   end

   assign memory_data_read  = data_read_r;
   assign memory_busy       = busy_r;
   assign memory_done       = done_r;
   assign memory_misaligned = mis_r;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: table-driven directed vectors for data_memory plus hand sequences for
// reset-during-WAIT and request toggling while busy.
module tb_data_memory;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd, wr, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [31:0] data_read;
   logic        busy, done, misaligned;

   int n_vec = 0;
   int errs  = 0;
   logic [31:0] last_rd;

   data_memory #(.DEPTH(256), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst_n(rst_n),
      .memory_read(rd), .memory_write(wr),
      .memory_size(size), .memory_unsigned(uns),
      .memory_address(addr), .memory_data_write(wdata),
      .memory_data_read(data_read), .memory_busy(busy),
      .memory_done(done), .memory_misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr, wdata, exp_data;
      logic        exp_mis;
   } vec_t;

   vec_t tbl [40];
   int   ntbl = 0;

   function automatic void add(input logic r, w, input logic [1:0] s, input logic u,
                               input logic [31:0] a, wd, ed, input logic em);
      tbl[ntbl].rd = r; tbl[ntbl].wr = w; tbl[ntbl].size = s; tbl[ntbl].uns = u;
      tbl[ntbl].addr = a; tbl[ntbl].wdata = wd; tbl[ntbl].exp_data = ed; tbl[ntbl].exp_mis = em;
      ntbl++;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One access: present at a negedge, accepted at the next posedge, then poll at negedges.
   task automatic apply(input string name, input logic r, w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, wd, ed, input logic em);
      logic got, busy_ok, busy_at_done, mis_v;
      logic [31:0] dat_v, exp_v;
      int cyc;
      @(negedge clk);
      rd = r; wr = w; size = s; uns = u; addr = a; wdata = wd;
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0;
      cyc = 1; got = 1'b0; busy_ok = 1'b1; busy_at_done = 1'b0; mis_v = 1'b0; dat_v = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1; mis_v = misaligned; dat_v = data_read; busy_at_done = busy;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         cyc++;
      end
      check({name, " done_seen"}, {31'd0, got}, 32'd1);
      if (got) begin
         exp_v = (r && !w && !em) ? ed : last_rd;
         check({name, " latency"}, cyc, LATENCY);
         check({name, " busy_wait"}, {31'd0, busy_ok}, 32'd1);
         check({name, " busy_done"}, {31'd0, busy_at_done}, 32'd0);
         check({name, " misaligned"}, {31'd0, mis_v}, {31'd0, em});
         check({name, " data"}, dat_v, exp_v);
         last_rd = exp_v;
      end
   endtask

   initial begin
      int pulses;
      logic [31:0] dat_t;

      // rd wr size uns addr wdata exp_data exp_mis
      add(0, 1, 2'b10, 0, 32'h10,  32'h80FF7F01, 32'h0,        0);
      add(1, 0, 2'b10, 0, 32'h10,  32'h0,        32'h80FF7F01, 0);
`ifdef MEMORY_BIG_ENDIAN_EN
      add(1, 0, 2'b00, 0, 32'h12,  32'h0,        32'h0000007F, 0);
      add(1, 0, 2'b00, 1, 32'h12,  32'h0,        32'h0000007F, 0);
      add(1, 0, 2'b01, 0, 32'h12,  32'h0,        32'h00007F01, 0);
      add(1, 0, 2'b01, 1, 32'h12,  32'h0,        32'h00007F01, 0);
      add(1, 0, 2'b00, 0, 32'h11,  32'h0,        32'hFFFFFFFF, 0);
      add(1, 0, 2'b00, 1, 32'h10,  32'h0,        32'h00000080, 0);
      add(1, 0, 2'b01, 0, 32'h10,  32'h0,        32'hFFFF80FF, 0);
`else
      add(1, 0, 2'b00, 0, 32'h12,  32'h0,        32'hFFFFFFFF, 0);
      add(1, 0, 2'b00, 1, 32'h12,  32'h0,        32'h000000FF, 0);
      add(1, 0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFF80FF, 0);
      add(1, 0, 2'b01, 1, 32'h12,  32'h0,        32'h000080FF, 0);
      add(1, 0, 2'b00, 0, 32'h11,  32'h0,        32'h0000007F, 0);
      add(1, 0, 2'b00, 1, 32'h10,  32'h0,        32'h00000001, 0);
      add(1, 0, 2'b01, 0, 32'h10,  32'h0,        32'h00007F01, 0);
`endif
      add(1, 0, 2'b11, 0, 32'h10,  32'h0,        32'h80FF7F01, 0);
      add(0, 1, 2'b10, 0, 32'h20,  32'h0,        32'h0,        0);
      add(0, 1, 2'b00, 0, 32'h21,  32'h123456AB, 32'h0,        0);
      add(0, 1, 2'b01, 0, 32'h22,  32'h0000CDEF, 32'h0,        0);
`ifdef MEMORY_BIG_ENDIAN_EN
      add(1, 0, 2'b10, 0, 32'h20,  32'h0,        32'h00ABCDEF, 0);
      add(1, 0, 2'b00, 0, 32'h23,  32'h0,        32'hFFFFFFEF, 0);
`else
      add(1, 0, 2'b10, 0, 32'h20,  32'h0,        32'hCDEFAB00, 0);
      add(1, 0, 2'b00, 0, 32'h23,  32'h0,        32'hFFFFFFCD, 0);
`endif
      add(1, 0, 2'b10, 0, 32'h11,  32'h0,        32'h0,        1);
      add(0, 1, 2'b01, 0, 32'h13,  32'h00001234, 32'h0,        1);
      add(1, 0, 2'b01, 1, 32'h11,  32'h0,        32'h0,        1);
      add(0, 1, 2'b10, 0, 32'h12,  32'hFFFFFFFF, 32'h0,        1);
      add(1, 0, 2'b10, 0, 32'h10,  32'h0,        32'h80FF7F01, 0);
`ifdef MEMORY_BIG_ENDIAN_EN
      add(1, 0, 2'b01, 1, 32'h12,  32'h0,        32'h00007F01, 0);
`else
      add(1, 0, 2'b01, 1, 32'h12,  32'h0,        32'h000080FF, 0);
`endif
      add(0, 1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 32'h0,        0);
      add(1, 0, 2'b10, 0, 32'h0,   32'h0,        32'hDEADBEEF, 0);
      add(1, 1, 2'b10, 0, 32'h40,  32'h11223344, 32'h0,        0);
      add(1, 0, 2'b10, 0, 32'h40,  32'h0,        32'h11223344, 0);
      add(0, 1, 2'b10, 0, 32'h30,  32'h0,        32'h0,        0);

      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
      last_rd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset data_read", data_read, 32'h0);
      check("reset flags", {29'd0, busy, done, misaligned}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < ntbl; i++) begin
         apply($sformatf("v%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].uns,
               tbl[i].addr, tbl[i].wdata, tbl[i].exp_data, tbl[i].exp_mis);
      end

      // Reset pulsed during WAIT drops the pending write
      @(negedge clk);
      wr = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'h55555555;
      @(posedge clk);
      #1;
      wr = 1'b0;
      @(negedge clk);
      check("wait busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midreset data_read", data_read, 32'h0);
      check("midreset flags", {29'd0, busy, done, misaligned}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      last_rd = '0;
      apply("after_reset lw30", 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);

      // Toggling read/write while busy must produce exactly one done pulse and no write
      @(negedge clk);
      rd = 1'b1; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10; wdata = 32'h0;
      @(posedge clk);
      #1;
      pulses = 0; dat_t = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            dat_t = data_read;
         end
         if (busy) begin
            rd = ~rd; wr = ~wr;
         end else begin
            rd = 1'b0; wr = 1'b0;
         end
      end
      check("toggle done_pulses", pulses, 32'd1);
      check("toggle data", dat_t, 32'h80FF7F01);
      last_rd = 32'h80FF7F01;
      apply("toggle no_write", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80FF7F01, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Parametrised successor to the single-cycle word memory in the MIPS datapath. Adds sized accesses (byte/half/word) with sign/zero extension and byte-lane write masking. Adds a configurable access latency with a busy/done handshake and misalignment detection. Sits between the MEM stage and the backing RAM array; the pipeline stalls on memory_busy.

Parameters:
DEPTH, 256, number of `WIDTH-bit words (power of two, >= 2); `WIDTH fixed at 32 from memory.vh
LATENCY, 2, cycles from request acceptance to memory_done (>= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
memory_read  input  1  read request (sampled only in IDLE)
memory_write  input  1  write request (sampled only in IDLE)
memory_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
memory_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend
memory_address  input  `WIDTH  byte address
memory_data_write  input  `WIDTH  store data, right-justified
memory_data_read  output  `WIDTH  load result, valid when memory_done=1, held until next accepted read
memory_busy  output  1  request in flight; new requests ignored
memory_done  output  1  one-cycle completion pulse
memory_misaligned  output  1  valid with memory_done; access was suppressed

Behaviour:
- Reset (async, rst_n=0): FSM→IDLE; memory_data_read=0, memory_busy=0, memory_done=0, memory_misaligned=0, latency counter=0. RAM contents not cleared.
- Reset mid-operation: in-flight request dropped; a pending write is never committed.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on an edge with memory_read|memory_write:
  - latch address, size, unsigned, data and op;
  - counter=LATENCY-1; busy=1;
  - go to DONE if LATENCY==1, else WAIT.
- Simultaneous read and write: treated as write only.
- WAIT: decrement counter each cycle; at 1 go to DONE. Input changes are ignored.
- DONE (one cycle):
  - done=1, busy=0;
  - write committed at the edge entering IDLE; read data registered at the same edge, visible during DONE;
  - return to IDLE. A request present in DONE is not accepted; it is accepted on the next IDLE edge.
- Latency: request accepted at edge N → done high in the cycle after edge N+LATENCY-1; back-to-back throughput one access per LATENCY+1 cycles.
- Word index = memory_address[log2(DEPTH)+1:2]; upper bits ignored, so addresses wrap modulo 4*DEPTH bytes.
- Lane a = address[1:0]:
  - little-endian byte lane = bits [8a+7:8a];
  - half lane = bits [16*a[1]+15:16*a[1]].
- Stores write only the selected lanes (byte enables); other bytes are preserved. Store data comes from memory_data_write[7:0] or [15:0].
- Loads: selected lane extended to 32 bits per memory_unsigned.
- Misaligned (half with a[0]=1, word with a!=0):
  - no RAM read or write;
  - follows the normal latency;
  - done=1 with misaligned=1;
  - memory_data_read unchanged.
- memory_misaligned = 0 for aligned completions; it is cleared when FSM leaves DONE.

Optional Feature:
MEMORY_BIG_ENDIAN_EN:
- Defined: MIPS big-endian lane mapping; byte lane a = bits [31-8a:24-8a]; half lane = bits [31-16*a[1]:16-16*a[1]].
- Undefined: little-endian mapping as in Behaviour.
- Word accesses are identical in both modes.

Test Plan:
- Word write 0x80FF7F01 @0x10, then word read @0x10 → done exactly LATENCY cycles after acceptance (2 with defaults), busy high in between; data_read=0x80FF7F01, misaligned=0.
- Loads from that word (LE):
  - lb @0x12 → 0xFFFFFFFF;
  - lbu @0x12 → 0x000000FF;
  - lh @0x12 → 0xFFFF80FF;
  - lhu @0x12 → 0x000080FF;
  - lb @0x11 → 0x0000007F.
  - With MEMORY_BIG_ENDIAN_EN defined: lbu @0x10 → 0x00000080.
- Word write 0 @0x20, sb 0x123456AB @0x21, sh 0xCDEF @0x22, word read @0x20 (LE) → 0xCDEFAB00.
- lw @0x11 and sh @0x13 → done with misaligned=1; subsequent word reads @0x10 and @0x12 region still return 0x80FF7F01; memory_data_read unchanged during the misaligned completions.
- Word write 0xDEADBEEF @0x400 (DEPTH=256), then word read @0x0 → 0xDEADBEEF (wrap).
- Word write 0x55555555 @0x30 issued, rst_n pulsed low during WAIT → outputs 0 immediately, FSM IDLE. After reset, word read @0x30 returns the prior contents (e.g. 0 after an initial word write of 0). Read/write toggled while busy → no extra done pulses.
